// File: rtl/btc_psum_accum.sv
// K-tile partial-sum accumulator: per-lane saturating accumulation, optional
// ReLU on the completed vector, and a small FIFO draining over valid/ready.
module btc_psum_accum #(
   parameter int LANES      = 16,
   parameter int LANE_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*LANE_W-1:0] in_data,
   input  logic                    in_first,
   input  logic                    in_last,
   input  logic                    relu_en,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*LANE_W-1:0] out_data,
   output logic                    sat_flag,
   output logic                    proto_err,
   input  logic                    clr_flags,
   output logic [15:0]             vec_count
);
   localparam int DATA_W = LANES * LANE_W;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [LANE_W-1:0] SAT_MAX = {1'b0, {(LANE_W-1){1'b1}}};
   localparam logic [LANE_W-1:0] SAT_MIN = {1'b1, {(LANE_W-1){1'b0}}};

   typedef enum logic {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_t;

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] acc_reg, acc_next;
   logic [DATA_W-1:0] beat_vec;
   logic [DATA_W-1:0] push_vec;
   logic [LANES-1:0]  lane_ovf;
   logic              accept, push, pop, start_beat;
   logic              sat_event, proto_event;

   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic [DATA_W-1:0] out_data_reg, out_data_next;
   logic              sat_flag_reg, sat_flag_next;
   logic              proto_err_reg, proto_err_next;
   logic [15:0]       vec_count_reg, vec_count_next;

   assign in_ready   = (count_reg < DEPTH_C);
   assign out_valid  = (count_reg != '0);
   assign out_data   = out_data_reg;
   assign sat_flag   = sat_flag_reg;
   assign proto_err  = proto_err_reg;
   assign vec_count  = vec_count_reg;

   assign accept     = in_valid & in_ready;
   assign push       = accept & in_last;
   assign pop        = out_valid & out_ready;
   // A beat opens a fresh vector when nothing is open or when it carries in_first.
   assign start_beat = (state_reg == ST_IDLE) | in_first;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [LANE_W-1:0] a_lane;
         logic [LANE_W-1:0] b_lane;
         logic [LANE_W:0]   sum_lane;
         logic              ovf_lane;
         logic [LANE_W-1:0] res_lane;

         assign a_lane   = acc_reg[gi*LANE_W +: LANE_W];
         assign b_lane   = in_data[gi*LANE_W +: LANE_W];
         assign sum_lane = {a_lane[LANE_W-1], a_lane} + {b_lane[LANE_W-1], b_lane};
         // Top two sum bits disagree exactly when the signed result left range.
         assign ovf_lane = sum_lane[LANE_W] ^ sum_lane[LANE_W-1];
         assign res_lane = start_beat ? b_lane :
                           ovf_lane   ? (sum_lane[LANE_W] ? SAT_MIN : SAT_MAX) :
                                        sum_lane[LANE_W-1:0];

         assign lane_ovf[gi]                       = ovf_lane & ~start_beat;
         assign beat_vec[gi*LANE_W +: LANE_W]      = res_lane;
         assign push_vec[gi*LANE_W +: LANE_W]      = (relu_en && res_lane[LANE_W-1]) ? '0 : res_lane;
      end
   endgenerate

   assign sat_event   = accept & (|lane_ovf);
   assign proto_event = accept & ((state_reg == ST_IDLE) ^ in_first);

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      if (accept) begin
         acc_next   = in_last ? '0 : beat_vec;
         state_next = in_last ? ST_IDLE : ST_ACCUM;
      end
   end

   always_comb begin
      wr_ptr_next    = wr_ptr_reg;
      rd_ptr_next    = rd_ptr_reg;
      count_next     = count_reg;
      out_data_next  = out_data_reg;
      vec_count_next = vec_count_reg;
      if (push) begin
         wr_ptr_next    = wr_ptr_reg + PTR_W'(1);
         vec_count_next = vec_count_reg + 16'd1;
      end
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
      // Registered head read; a push landing in the new head slot bypasses the array.
      if (count_next != '0) begin
         if (push && (wr_ptr_reg == rd_ptr_next)) begin
            out_data_next = push_vec;
         end else begin
            out_data_next = fifo_mem[rd_ptr_next];
         end
      end
   end

   // Set wins over a same-cycle clear.
   always_comb begin
      sat_flag_next  = (sat_flag_reg & ~clr_flags) | sat_event;
      proto_err_next = (proto_err_reg & ~clr_flags) | proto_event;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg     <= ST_IDLE;
         acc_reg       <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         out_data_reg  <= '0;
         sat_flag_reg  <= 1'b0;
         proto_err_reg <= 1'b0;
         vec_count_reg <= '0;
      end else begin
         state_reg     <= state_next;
         acc_reg       <= acc_next;
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         count_reg     <= count_next;
         out_data_reg  <= out_data_next;
         sat_flag_reg  <= sat_flag_next;
         proto_err_reg <= proto_err_next;
         vec_count_reg <= vec_count_next;
      end
   end

   // Storage needs no reset: a slot is only read after being written post-reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= push_vec;
      end
   end

endmodule

// File: tb/tb_btc_psum_accum.sv
// Scoreboarded bench for btc_psum_accum: directed scenarios plus randomized
// K-tile traffic against an integer-arithmetic reference model.
module tb_btc_psum_accum;
   localparam int LANES      = 16;
   localparam int LANE_W     = 32;
   localparam int FIFO_DEPTH = 4;
   localparam int DW         = LANES * LANE_W;
   localparam longint LMAX   = 64'sd2147483647;
   localparam longint LMIN   = -64'sd2147483648;

   logic          clk;
   logic          rstn;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_first;
   logic          in_last;
   logic          relu_en;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          sat_flag;
   logic          proto_err;
   logic          clr_flags;
   logic [15:0]   vec_count;

   btc_psum_accum #(
      .LANES(LANES), .LANE_W(LANE_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_first(in_first), .in_last(in_last), .relu_en(relu_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sat_flag(sat_flag), .proto_err(proto_err), .clr_flags(clr_flags),
      .vec_count(vec_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model state
   longint        m_acc [LANES];
   bit            m_open;
   bit            m_sat;
   bit            m_proto;
   int unsigned   m_vcnt;
   logic [DW-1:0] exp_q [$];

   int  errors = 0;
   int  checks = 0;
   int  pops   = 0;
   bit  rdy_hold = 1'b1;
   bit  rdy_rand = 1'b0;
   logic [DW-1:0] mon_exp;

   task automatic model_beat(input logic [DW-1:0] d, input bit first, input bit last, input bit relu);
      logic [DW-1:0]            v;
      logic signed [LANE_W-1:0] lv;
      longint                   x;
      longint                   s;
      bit                       start;
      v = '0;
      start = !m_open || first;
      if (m_open == first) m_proto = 1'b1;
      for (int i = 0; i < LANES; i++) begin
         lv = d[i*LANE_W +: LANE_W];
         x  = lv;
         s  = start ? x : (m_acc[i] + x);
         if (s > LMAX) begin
            s = LMAX;
            m_sat = 1'b1;
         end else if (s < LMIN) begin
            s = LMIN;
            m_sat = 1'b1;
         end
         m_acc[i] = s;
         v[i*LANE_W +: LANE_W] = (relu && s < 0) ? '0 : LANE_W'(s);
      end
      if (last) begin
         exp_q.push_back(v);
         m_vcnt++;
         m_open = 1'b0;
      end else begin
         m_open = 1'b1;
      end
   endtask

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] splat(input int v);
      logic [DW-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*LANE_W +: LANE_W] = v;
      return r;
   endfunction

   function automatic logic [DW-1:0] lanes2(input int a, input int b);
      logic [DW-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*LANE_W +: LANE_W] = (i % 2 == 0) ? a : b;
      return r;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [DW-1:0] d, input bit first, input bit last, input bit relu);
      int w;
      in_valid = 1'b1;
      in_data  = d;
      in_first = first;
      in_last  = last;
      relu_en  = relu;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         w++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready got 0 expected 1");
         @(posedge clk);
      end else begin
         @(posedge clk);
         model_beat(d, first, last, relu);
      end
      #1;
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rstn      = 1'b0;
      in_valid  = 1'b0;
      in_first  = 1'b0;
      in_last   = 1'b0;
      clr_flags = 1'b0;
      cyc(n);
      rstn = 1'b1;
      exp_q.delete();
      m_open  = 1'b0;
      m_sat   = 1'b0;
      m_proto = 1'b0;
      m_vcnt  = 0;
   endtask

   task automatic clear_flags();
      clr_flags = 1'b1;
      cyc(1);
      clr_flags = 1'b0;
      m_sat   = 1'b0;
      m_proto = 1'b0;
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while ((exp_q.size() != 0 || out_valid) && w < 300) begin
         cyc(1);
         w++;
      end
      chk("drain_out_valid", out_valid, 0);
      chk("drain_pending", exp_q.size(), 0);
   endtask

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_hold)      out_ready = 1'b0;
         else if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
         else               out_ready = 1'b1;
      end
   end

   // Monitor: a pop happens at the next edge whenever valid & ready at the negedge.
   always @(negedge clk) begin
      if (rstn && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got %h expected none", out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            pops++;
            if (out_data !== mon_exp) begin
               errors++;
               $display("FAIL pop_data #%0d: got %h expected %h", pops, out_data, mon_exp);
            end else begin
               $display("pop #%0d ok lane0=%0d lane1=%0d", pops,
                        $signed(out_data[LANE_W-1:0]), $signed(out_data[2*LANE_W-1:LANE_W]));
            end
         end
      end
   end

   initial begin
      int nb;
      int mode;
      bit first;
      bit relu;
      logic [DW-1:0] d;

      rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_first = 1'b0;
      in_last = 1'b0; relu_en = 1'b0; clr_flags = 1'b0;
      for (int i = 0; i < LANES; i++) m_acc[i] = 0;
      do_reset(3);

      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_vec_count", vec_count, 0);
      chk("reset_sat_flag", sat_flag, 0);
      chk("reset_proto_err", proto_err, 0);
      chk("reset_out_data_nonzero", longint'(|out_data), 0);

      // Three-beat vector: 5 - 2 + 10 = 13
      rdy_hold = 1'b1;
      send(splat(5), 1'b1, 1'b0, 1'b0);
      send(splat(-2), 1'b0, 1'b0, 1'b0);
      send(splat(10), 1'b0, 1'b1, 1'b0);
      chk("latency_out_valid", out_valid, 1);
      chk("vec_count_1", vec_count, 1);
      chk("sat_flag_clean", sat_flag, 0);
      rdy_hold = 1'b0;
      wait_drain();

      // Single-beat vector with ReLU
      send(lanes2(7, -7), 1'b1, 1'b1, 1'b1);
      wait_drain();

      // Positive and negative saturation
      send(splat(32'h7FFFFFF0), 1'b1, 1'b0, 1'b0);
      send(splat(32'h00000100), 1'b0, 1'b1, 1'b0);
      chk("sat_flag_pos", sat_flag, 1);
      wait_drain();
      clear_flags();
      chk("sat_flag_cleared", sat_flag, 0);
      send(lanes2(-2147483600, 100), 1'b1, 1'b0, 1'b0);
      send(lanes2(-1000, -300), 1'b0, 1'b1, 1'b0);
      chk("sat_flag_neg", sat_flag, m_sat);
      wait_drain();
      clear_flags();

      // Full FIFO back-pressure and in-order delivery
      rdy_hold = 1'b1;
      cyc(2);
      for (int v = 1; v <= 4; v++) send(splat(v), 1'b1, 1'b1, 1'b0);
      chk("full_in_ready", in_ready, 0);
      cyc(3);
      chk("full_in_ready_hold", in_ready, 0);
      chk("full_vec_count", vec_count, m_vcnt & 16'hFFFF);
      rdy_hold = 1'b0;
      send(splat(5), 1'b1, 1'b1, 1'b0);
      wait_drain();

      // Protocol violations: missing first, then restart mid-vector
      send(splat(3), 1'b0, 1'b0, 1'b0);
      chk("proto_missing_first", proto_err, 1);
      send(splat(4), 1'b0, 1'b0, 1'b0);
      send(splat(100), 1'b1, 1'b0, 1'b0);
      send(splat(1), 1'b0, 1'b1, 1'b0);
      wait_drain();
      clear_flags();
      chk("proto_cleared", proto_err, 0);
      clr_flags = 1'b1;
      m_proto = 1'b0;
      send(splat(9), 1'b0, 1'b1, 1'b0);
      clr_flags = 1'b0;
      chk("proto_set_beats_clear", proto_err, m_proto);
      wait_drain();
      clear_flags();

      // Reset mid-tile with queued vectors
      rdy_hold = 1'b1;
      send(splat(11), 1'b1, 1'b1, 1'b0);
      send(splat(22), 1'b1, 1'b1, 1'b0);
      send(splat(50), 1'b1, 1'b0, 1'b0);
      do_reset(1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_vec_count", vec_count, 0);
      chk("rst_in_ready", in_ready, 1);
      rdy_hold = 1'b0;
      send(splat(6), 1'b1, 1'b0, 1'b0);
      send(splat(7), 1'b0, 1'b1, 1'b0);
      wait_drain();
      chk("rst_vec_count_after", vec_count, m_vcnt & 16'hFFFF);

      // Randomized traffic
      rdy_rand = 1'b1;
      for (int n = 0; n < 60; n++) begin
         nb   = $urandom_range(1, 4);
         mode = $urandom_range(0, 2);
         relu = $urandom_range(0, 1);
         for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < LANES; i++) begin
               case (mode)
                  0:       d[i*LANE_W +: LANE_W] = 32'(int'($urandom_range(0, 2000)) - 1000);
                  1:       d[i*LANE_W +: LANE_W] = $urandom;
                  default: d[i*LANE_W +: LANE_W] = ($urandom_range(0, 1) != 0) ?
                                                   32'h7FFFF000 + $urandom_range(0, 4095) :
                                                   32'h80000000 + $urandom_range(0, 4095);
               endcase
            end
            first = (b == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
            send(d, first, (b == nb - 1), relu);
         end
         if ($urandom_range(0, 3) == 0) cyc($urandom_range(1, 3));
      end
      rdy_rand = 1'b0;
      wait_drain();
      chk("final_vec_count", vec_count, m_vcnt & 16'hFFFF);
      chk("final_sat_flag", sat_flag, m_sat);
      chk("final_proto_err", proto_err, m_proto);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
